// File: rtl/snd_cmd_sequencer.sv
// Sound command sequencer: queues 6-bit commands and drives each onto the IP2720 bus for
// HOLD_CYCLES, then the idle code for GAP_CYCLES. Optional macro: SND_CMD_COALESCE_EN.
module snd_cmd_sequencer #(
   parameter int         DEPTH       = 8,
   parameter int         HOLD_CYCLES = 1024,
   parameter int         GAP_CYCLES  = 256,
   parameter logic [5:0] IDLE_CODE   = 6'h00
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [5:0]               wr_data,
   input  logic                     flush,
   output logic [5:0]               ip2720,
   output logic                     busy,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW + 1;
   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_GAP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [5:0]      ip_q, ip_d;
   logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d, waddr;
   logic [LW-1:0]   level_q, level_d;
   logic            full_q;
   logic            ovf_q, ovf_d;
   logic [5:0]      mem_q [DEPTH];
   logic            pop, accept, coalesce_drop;

   assign pop = (state_q == ST_IDLE) && (level_q != '0);

`ifdef SND_CMD_COALESCE_EN
   logic [5:0] last_q;
   logic       last_vld_q, last_vld_d;

   // The tail entry is the one popping only when it is the sole occupant.
   assign coalesce_drop = wr_en && !flush && last_vld_q && (wr_data == last_q)
                          && !(pop && (level_q == LW'(1)));

   always_comb begin
      last_vld_d = last_vld_q;
      if (pop && (level_q == LW'(1))) last_vld_d = 1'b0;
      if (flush)                      last_vld_d = 1'b0;
      if (accept)                     last_vld_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) last_vld_q <= 1'b0;
      else       last_vld_q <= last_vld_d;
      if (accept) last_q <= wr_data;
   end
`else
   assign coalesce_drop = 1'b0;
`endif

   assign accept = wr_en && !coalesce_drop && (flush || (level_q != LW'(DEPTH)) || pop);
   assign waddr  = flush ? '0 : wptr_q;

   always_comb begin
      rptr_d  = pop    ? rptr_q + AW'(1) : rptr_q;
      wptr_d  = accept ? wptr_q + AW'(1) : wptr_q;
      level_d = level_q;
      if (accept && !pop)      level_d = level_q + LW'(1);
      else if (!accept && pop) level_d = level_q - LW'(1);
      ovf_d   = ovf_q | (wr_en && !accept && !coalesce_drop);
      // A write alongside flush lands at slot 0 as the only entry.
      if (flush) begin
         rptr_d  = '0;
         wptr_d  = accept ? AW'(1) : '0;
         level_d = accept ? LW'(1) : '0;
         ovf_d   = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ip_d    = ip_q;
      case (state_q)
         ST_IDLE: begin
            ip_d = IDLE_CODE;
            if (pop) begin
               ip_d    = mem_q[rptr_q];
               cnt_d   = CW'(HOLD_CYCLES - 1);
               state_d = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (cnt_q == '0) begin
               ip_d    = IDLE_CODE;
               cnt_d   = CW'(GAP_CYCLES - 1);
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: begin
            state_d = ST_IDLE;
            ip_d    = IDLE_CODE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ip_q    <= IDLE_CODE;
         rptr_q  <= '0;
         wptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ip_q    <= ip_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         level_q <= level_d;
         full_q  <= (level_d == LW'(DEPTH));
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem_q[waddr] <= wr_data;
   end

   assign ip2720   = ip_q;
   assign busy     = (state_q != ST_IDLE) | (level_q != '0);
   assign full     = full_q;
   assign level    = level_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_snd_cmd_sequencer.sv
// Directed bench for snd_cmd_sequencer with DEPTH=4, HOLD=4, GAP=2, idle code 0.
module tb_snd_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [5:0] wr_data = 6'h00;
   logic       flush = 1'b0;
   logic [5:0] ip2720;
   logic       busy, full, overflow;
   logic [2:0] level;

   int total = 0;
   int bad   = 0;

   snd_cmd_sequencer #(
      .DEPTH(4), .HOLD_CYCLES(4), .GAP_CYCLES(2), .IDLE_CODE(6'h00)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
      .ip2720(ip2720), .busy(busy), .full(full), .level(level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [5:0] d);
      wr_en = 1'b1; wr_data = d;
      step(1);
      wr_en = 1'b0;
   endtask

   initial begin
      // reset state
      step(3);
      chk("rst_ip", ip2720, 6'h00);
      chk("rst_busy", busy, 0);
      chk("rst_full", full, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b0;
      step(1);

      // single command timing
      wr(6'h15);
      chk("t1_lvl_after_wr", level, 1);
      chk("t1_ip_after_wr", ip2720, 6'h00);
      chk("t1_busy_after_wr", busy, 1);
      step(1);
      chk("t1_ip_first", ip2720, 6'h15);
      chk("t1_lvl_pop", level, 0);
      step(3);
      chk("t1_ip_last_hold", ip2720, 6'h15);
      step(1);
      chk("t1_ip_gap", ip2720, 6'h00);
      chk("t1_busy_gap", busy, 1);
      step(1);
      chk("t1_busy_gap2", busy, 1);
      step(1);
      chk("t1_busy_done", busy, 0);

      // fill and overflow
      for (int i = 1; i <= 5; i++) wr(6'(i));
      chk("t2_lvl_full", level, 4);
      chk("t2_full", full, 1);
      chk("t2_ovf0", overflow, 0);
      chk("t2_ip01", ip2720, 6'h01);
      wr(6'h06);
      chk("t2_ovf1", overflow, 1);
      chk("t2_lvl_drop", level, 4);
      chk("t2_ip_gap", ip2720, 6'h00);
      step(3);
      chk("t2_ip02", ip2720, 6'h02);
      chk("t2_lvl3", level, 3);
      chk("t2_notfull", full, 0);
      step(7);
      chk("t2_ip03", ip2720, 6'h03);
      step(7);
      chk("t2_ip04", ip2720, 6'h04);
      step(7);
      chk("t2_ip05", ip2720, 6'h05);
      chk("t2_lvl0", level, 0);
      step(7);
      chk("t2_no06", ip2720, 6'h00);
      chk("t2_idle", busy, 0);
      chk("t2_ovf_sticky", overflow, 1);

      // flush clears overflow; write accepted on full FIFO with a pop
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      chk("t3_flush_ovf", overflow, 0);
      wr(6'h11); wr(6'h21); wr(6'h22); wr(6'h23); wr(6'h24);
      chk("t3_lvl4", level, 4);
      chk("t3_ip11", ip2720, 6'h11);
      step(3);
      chk("t3_idle_full", level, 4);
      chk("t3_ip_idle", ip2720, 6'h00);
      wr(6'h2A);
      chk("t3_lvl_same", level, 4);
      chk("t3_full_same", full, 1);
      chk("t3_ovf_none", overflow, 0);
      chk("t3_ip21", ip2720, 6'h21);
      step(7);
      chk("t3_ip22", ip2720, 6'h22);
      step(7);
      chk("t3_ip23", ip2720, 6'h23);
      step(7);
      chk("t3_ip24", ip2720, 6'h24);
      step(7);
      chk("t3_ip2A", ip2720, 6'h2A);
      chk("t3_lvl_end", level, 0);
      step(7);
      chk("t3_idle", busy, 0);

      // flush during ASSERT
      wr(6'h33); wr(6'h34); wr(6'h35); wr(6'h36);
      chk("t4_lvl3", level, 3);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      chk("t4_lvl0", level, 0);
      chk("t4_ovf0", overflow, 0);
      chk("t4_hold33", ip2720, 6'h33);
      chk("t4_busy", busy, 1);
      step(1);
      chk("t4_gap_ip", ip2720, 6'h00);
      chk("t4_gap_busy", busy, 1);
      step(2);
      chk("t4_done", busy, 0);
      step(1);
      chk("t4_no_more", ip2720, 6'h00);

      // reset mid-ASSERT
      wr(6'h3E); wr(6'h3D);
      step(1);
      chk("t5_ip3E", ip2720, 6'h3E);
      chk("t5_lvl1", level, 1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("t5_rst_ip", ip2720, 6'h00);
      chk("t5_rst_lvl", level, 0);
      chk("t5_rst_busy", busy, 0);
      wr(6'h12);
      chk("t5_wr_lvl", level, 1);
      chk("t5_wr_ip", ip2720, 6'h00);
      step(1);
      chk("t5_ip12", ip2720, 6'h12);

      // duplicate writes while a command is active
      wr(6'h07); wr(6'h07);
`ifdef SND_CMD_COALESCE_EN
      chk("t6_lvl_coalesce", level, 1);
`else
      chk("t6_lvl_plain", level, 2);
`endif
      chk("t6_ovf", overflow, 0);

      // flush with a simultaneous write keeps that write
      flush = 1'b1;
      wr(6'h09);
      flush = 1'b0;
      chk("t7_lvl1", level, 1);
      chk("t7_ovf", overflow, 0);
      step(4);
      chk("t7_ip09", ip2720, 6'h09);
      chk("t7_lvl0", level, 0);

      for (int i = 0; i < 50 && busy; i++) step(1);
      chk("drain_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
